// File: rtl/issue_unit.sv
// issue_unit: dispatch stage feeding the floating adder reservation stations.
//
// Fetched 16-bit instructions queue in a DEPTH-entry FIFO. The head is
// decoded against a 16-entry register file plus a per-register rename tag
// table, and a 51-bit station line is presented combinationally whenever
// the head can dispatch. The float and load result buses are snooped for
// operand bypass, register writeback and jeq resolution.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   instrValid/instr/instrReady    fetch handshake (instrReady = FIFO not full)
//   nextRA                         free station index, 4'hF = none free
//   writeEnabled/line              station write strobe and entry (0 when idle)
//   floatOut*/isJeq/jeqTaken       adder result bus, also carries jeq outcome
//   loadOut*                       load result bus
//   flush                          one-cycle pulse after a taken jeq
//   illegal                        one-cycle pulse after an unsupported op pops
//   dbgAddr/dbgData                combinational register file peek

// One operand read port: register value, same-cycle bus bypass, or tag.
module issue_operand (
    input  logic [15:0] regval,
    input  logic        busy,
    input  logic [3:0]  tag,
    input  logic        fvld,
    input  logic [3:0]  fsrc,
    input  logic [15:0] fval,
    input  logic        lvld,
    input  logic [3:0]  lsrc,
    input  logic [15:0] lval,
    output logic [15:0] value,
    output logic        ready,
    output logic [3:0]  src
);
    always_comb begin
        value = 16'h0;
        ready = 1'b0;
        src   = tag;
        if (!busy) begin
            value = regval;
            ready = 1'b1;
            src   = 4'hF;
        end else if (fvld && fsrc == tag) begin
            value = fval;
            ready = 1'b1;
            src   = 4'hF;
        end else if (lvld && lsrc == tag) begin
            value = lval;
            ready = 1'b1;
            src   = 4'hF;
        end
    end
endmodule

module issue_unit #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instrValid,
    input  logic [15:0] instr,
    output logic        instrReady,
    input  logic [3:0]  nextRA,
    output logic        writeEnabled,
    output logic [50:0] line,
    input  logic        floatOutReady,
    input  logic [15:0] floatOut,
    input  logic [3:0]  floatOutSrc,
    input  logic [3:0]  floatOutReg,
    input  logic        isJeq,
    input  logic        jeqTaken,
    input  logic        loadOutReady,
    input  logic [15:0] loadOut,
    input  logic [3:0]  loadOutSrc,
    output logic        flush,
    output logic        illegal,
    input  logic [3:0]  dbgAddr,
    output logic [15:0] dbgData
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam int NOPND = 2;

    typedef struct packed {
        logic [3:0]  rd;
        logic        busy;
        logic [3:0]  op;
        logic [15:0] v0;
        logic        r0;
        logic [3:0]  s0;
        logic [15:0] v1;
        logic        r1;
        logic [3:0]  s1;
    } line_t;

    logic [DEPTH-1:0][15:0] fifo;
    logic [AW-1:0]          wp, rp;
    logic [AW:0]            cnt;

    logic [15:0][15:0]      regs;
    logic [15:0]            busy;
    logic [15:0][3:0]       tag;
    logic                   jeq_pend;

    logic [15:0] head;
    logic [3:0]  op, rd, ra, rb;
    logic        empty, legal, dispatch, bad, pop, push;
    logic        fvld, jeq_res, do_flush, renames;
    logic [15:0] fwb, lwb, ren;
    line_t       ln;

    assign head  = fifo[rp];
    assign op    = head[15:12];
    assign rd    = head[11:8];
    assign ra    = head[7:4];
    assign rb    = head[3:0];
    assign empty = (cnt == '0);
    assign legal = (op == 4'd1) || (op == 4'd5) || (op == 4'd6);

    assign instrReady = (cnt != FULL);
    assign push       = instrValid && instrReady;
    // Nothing leaves the head while a jeq is unresolved; it may be flushed.
    assign dispatch   = !empty && legal && (nextRA != 4'hF) && !jeq_pend;
    assign bad        = !empty && !legal && !jeq_pend;
    assign pop        = dispatch || bad;

    assign fvld     = floatOutReady && !isJeq;
    assign jeq_res  = floatOutReady && isJeq;
    assign do_flush = jeq_res && jeqTaken;
    assign renames  = dispatch && ((op == 4'd1) || (op == 4'd5));

    // Operand lanes: lane 0 reads ra, lane 1 reads rb.
    logic [NOPND-1:0][3:0]  opsel;
    logic [NOPND-1:0][15:0] oval;
    logic [NOPND-1:0]       ordy;
    logic [NOPND-1:0][3:0]  osrc;

    assign opsel = {rb, ra};

    genvar g;
    generate
        for (g = 0; g < NOPND; g++) begin : g_opnd
            issue_operand u_opnd (
                .regval(regs[opsel[g]]),
                .busy  (busy[opsel[g]]),
                .tag   (tag[opsel[g]]),
                .fvld  (fvld),
                .fsrc  (floatOutSrc),
                .fval  (floatOut),
                .lvld  (loadOutReady),
                .lsrc  (loadOutSrc),
                .lval  (loadOut),
                .value (oval[g]),
                .ready (ordy[g]),
                .src   (osrc[g])
            );
        end
    endgenerate

    always_comb begin
        ln = '0;
        if (dispatch) begin
            ln.rd   = rd;
            ln.busy = 1'b1;
            ln.op   = op;
            ln.v0   = oval[0];
            ln.r0   = ordy[0];
            ln.s0   = osrc[0];
            ln.v1   = oval[1];
            ln.r1   = ordy[1];
            ln.s1   = osrc[1];
            // Immediate form: rb field is the literal second operand.
            if (op == 4'd5) begin
                ln.v1 = {12'h0, rb};
                ln.r1 = 1'b1;
                ln.s1 = 4'hF;
            end
        end
    end

    assign line         = ln;
    assign writeEnabled = dispatch;
    assign dbgData      = regs[dbgAddr];

    // Per-register writeback and rename strobes.
    always_comb begin
        fwb = '0;
        lwb = '0;
        ren = '0;
        for (int i = 0; i < 16; i++) begin
            fwb[i] = fvld && (floatOutReg != 4'hF) && (floatOutReg == 4'(i)) &&
                     busy[i] && (tag[i] == floatOutSrc);
            lwb[i] = loadOutReady && busy[i] && (tag[i] == loadOutSrc);
            ren[i] = renames && (rd == 4'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo <= '0;
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
        end else if (do_flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                fifo[wp] <= instr;
                wp       <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Rename beats writeback on the same register: value lands, busy stays.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
            busy <= '0;
            tag  <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (fwb[i])
                    regs[i] <= floatOut;
                else if (lwb[i])
                    regs[i] <= loadOut;
                if (ren[i]) begin
                    busy[i] <= 1'b1;
                    tag[i]  <= nextRA;
                end else if (fwb[i] || lwb[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jeq_pend <= 1'b0;
            flush    <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            flush   <= do_flush;
            illegal <= bad;
            if (dispatch && op == 4'd6)
                jeq_pend <= 1'b1;
            else if (jeq_res)
                jeq_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_issue_unit.sv
module tb_issue_unit;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        instrValid;
    logic [15:0] instr;
    logic        instrReady;
    logic [3:0]  nextRA;
    logic        writeEnabled;
    logic [50:0] line;
    logic        floatOutReady;
    logic [15:0] floatOut;
    logic [3:0]  floatOutSrc;
    logic [3:0]  floatOutReg;
    logic        isJeq;
    logic        jeqTaken;
    logic        loadOutReady;
    logic [15:0] loadOut;
    logic [3:0]  loadOutSrc;
    logic        flush;
    logic        illegal;
    logic [3:0]  dbgAddr;
    logic [15:0] dbgData;

    issue_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .instrValid(instrValid), .instr(instr), .instrReady(instrReady),
        .nextRA(nextRA), .writeEnabled(writeEnabled), .line(line),
        .floatOutReady(floatOutReady), .floatOut(floatOut),
        .floatOutSrc(floatOutSrc), .floatOutReg(floatOutReg),
        .isJeq(isJeq), .jeqTaken(jeqTaken),
        .loadOutReady(loadOutReady), .loadOut(loadOut), .loadOutSrc(loadOutSrc),
        .flush(flush), .illegal(illegal),
        .dbgAddr(dbgAddr), .dbgData(dbgData)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: instruction queue, register values, rename state.
    logic [15:0] q[$];
    logic [15:0] mregs[16];
    logic        mbusy[16];
    logic [3:0]  mtag[16];
    logic        mpend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 16; i++) begin
            mregs[i] = 16'h0;
            mbusy[i] = 1'b0;
            mtag[i]  = 4'h0;
        end
        mpend = 1'b0;
    endtask

    function automatic logic is_legal(input logic [3:0] op);
        return op == 4'd1 || op == 4'd5 || op == 4'd6;
    endfunction

    function automatic logic exp_disp();
        if (q.size() == 0) return 1'b0;
        return is_legal(q[0][15:12]) && nextRA != 4'hF && !mpend;
    endfunction

    function automatic logic exp_bad();
        if (q.size() == 0) return 1'b0;
        return !is_legal(q[0][15:12]) && !mpend;
    endfunction

    function automatic void operand(input logic [3:0] r, output logic [15:0] v,
                                    output logic rdy, output logic [3:0] s);
        if (!mbusy[r]) begin
            v = mregs[r]; rdy = 1'b1; s = 4'hF;
        end else if (floatOutReady && !isJeq && floatOutSrc == mtag[r]) begin
            v = floatOut; rdy = 1'b1; s = 4'hF;
        end else if (loadOutReady && loadOutSrc == mtag[r]) begin
            v = loadOut; rdy = 1'b1; s = 4'hF;
        end else begin
            v = 16'h0; rdy = 1'b0; s = mtag[r];
        end
    endfunction

    function automatic logic [50:0] exp_line();
        logic [15:0] h, v0, v1;
        logic        r0, r1;
        logic [3:0]  s0, s1;
        if (!exp_disp()) return '0;
        h = q[0];
        operand(h[7:4], v0, r0, s0);
        operand(h[3:0], v1, r1, s1);
        if (h[15:12] == 4'd5) begin
            v1 = {12'h0, h[3:0]}; r1 = 1'b1; s1 = 4'hF;
        end
        return {h[11:8], 1'b1, h[15:12], v0, r0, s0, v1, r1, s1};
    endfunction

    // One clock: check combinational outputs, advance model at the edge,
    // then check the registered pulses. Enter and leave near a negedge.
    task automatic cycle();
        logic        d, il, fl, rdy;
        logic [15:0] h;
        logic        ob[16];
        logic [3:0]  ot[16];
        #1;
        chk("instrReady", instrReady, q.size() < DEPTH);
        chk("writeEnabled", writeEnabled, exp_disp());
        chk("line", line, exp_line());
        chk("dbgData", dbgData, mregs[dbgAddr]);
        d   = exp_disp();
        il  = exp_bad();
        fl  = floatOutReady && isJeq && jeqTaken;
        rdy = q.size() < DEPTH;
        h   = (q.size() > 0) ? q[0] : 16'h0;
        @(posedge clk);
        ob = mbusy;
        ot = mtag;
        if (floatOutReady && !isJeq && floatOutReg != 4'hF &&
            ob[floatOutReg] && ot[floatOutReg] == floatOutSrc) begin
            mregs[floatOutReg] = floatOut;
            mbusy[floatOutReg] = 1'b0;
        end
        if (loadOutReady)
            for (int i = 0; i < 16; i++)
                if (ob[i] && ot[i] == loadOutSrc) begin
                    mregs[i] = loadOut;
                    mbusy[i] = 1'b0;
                end
        if (d && (h[15:12] == 4'd1 || h[15:12] == 4'd5)) begin
            mbusy[h[11:8]] = 1'b1;
            mtag[h[11:8]]  = nextRA;
        end
        if (d && h[15:12] == 4'd6) mpend = 1'b1;
        else if (floatOutReady && isJeq) mpend = 1'b0;
        if (fl) q.delete();
        else begin
            if (d || il) void'(q.pop_front());
            if (instrValid && rdy) q.push_back(instr);
        end
        #1;
        chk("flush", flush, fl);
        chk("illegal", illegal, il);
        @(negedge clk);
    endtask

    task automatic quiet();
        instrValid = 0; instr = 0; floatOutReady = 0; floatOut = 0;
        floatOutSrc = 0; floatOutReg = 4'hF; isJeq = 0; jeqTaken = 0;
        loadOutReady = 0; loadOut = 0; loadOutSrc = 0;
    endtask

    task automatic push1(input logic [15:0] w);
        instrValid = 1; instr = w; cycle(); instrValid = 0;
    endtask

    task automatic drain();
        int n = 0;
        nextRA = 4'h0;
        while (q.size() > 0 && !mpend && n < 20) begin cycle(); n++; end
        chk("drain_bound", q.size() > 0 && !mpend, 1'b0);
    endtask

    initial begin
        quiet();
        nextRA = 4'hF; dbgAddr = 0; rst = 1;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_we", writeEnabled, 0); chk("rst_line", line, 0);
        chk("rst_flush", flush, 0); chk("rst_illegal", illegal, 0);
        chk("rst_ready", instrReady, 1); chk("rst_dbg", dbgData, 0);
        rst = 0;

        // Independent add dispatches one cycle after the push.
        push1(16'h1312);
        nextRA = 4'h0;
        #1 chk("add_line", line, {4'd3, 1'b1, 4'd1, 16'h0, 1'b1, 4'hF, 16'h0, 1'b1, 4'hF});
        cycle();

        // Dependent add waits on tag 0; float bus then retires r3.
        nextRA = 4'hF; push1(16'h1434);
        nextRA = 4'h1;
        #1 chk("dep_src0", line[25:21], 5'b0_0000);
        cycle();
        floatOutReady = 1; floatOutSrc = 0; floatOutReg = 3; floatOut = 16'h0042; dbgAddr = 3;
        cycle();
        quiet();
        #1 chk("wb_r3", dbgData, 16'h0042);

        // Bypass of a broadcast in the dispatch cycle.
        nextRA = 4'hF; push1(16'h1312);
        nextRA = 4'h0; cycle();
        nextRA = 4'hF; push1(16'h1534);
        nextRA = 4'h1; floatOutReady = 1; floatOutSrc = 0; floatOutReg = 3; floatOut = 16'h1234;
        #1 chk("bypass", line[41:21], {16'h1234, 1'b1, 4'hF});
        cycle();
        quiet();

        // Fill the FIFO with no free station; the ninth push is dropped.
        nextRA = 4'hF;
        for (int i = 0; i < 8; i++) push1({4'h1, 4'(i), 4'h1, 4'h2});
        #1 chk("full_ready", instrReady, 0);
        push1(16'h1999);
        nextRA = 4'h1; cycle();
        #1 chk("ready_again", instrReady, 1);
        drain();

        // Taken jeq: dispatch stalls, then flush empties the FIFO.
        nextRA = 4'hF;
        push1(16'h6512); push1(16'h1111); push1(16'h1222); push1(16'h1333);
        nextRA = 4'h0;
        #1 chk("jeq_we", writeEnabled, 1);
        cycle();
        for (int i = 0; i < 2; i++) begin
            #1 chk("jeq_stall", writeEnabled, 0);
            cycle();
        end
        floatOutReady = 1; isJeq = 1; jeqTaken = 1; instrValid = 1; instr = 16'h1777;
        cycle();
        quiet();
        #1 chk("flush_pulse", flush, 1);
        chk("flush_empty", writeEnabled, 0);
        cycle();

        // Not-taken jeq: dispatch resumes, no flush.
        nextRA = 4'hF; push1(16'h6512); push1(16'h1111);
        nextRA = 4'h0; cycle(); cycle();
        floatOutReady = 1; isJeq = 1; jeqTaken = 0;
        cycle();
        quiet();
        #1 chk("nt_flush", flush, 0);
        chk("nt_resume", writeEnabled, 1);
        drain();

        // Unsupported opcode pops and pulses illegal.
        nextRA = 4'h0; push1(16'hF123);
        #1 chk("ill_we", writeEnabled, 0);
        cycle();
        #1 chk("ill_pulse", illegal, 1);
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] op;
            int r, sel;
            sel = $urandom_range(0, 19);
            if (sel < 11) op = 4'd1;
            else if (sel < 16) op = 4'd5;
            else if (sel < 17) op = 4'd6;
            else op = 4'($urandom_range(7, 15));
            instrValid = $urandom_range(0, 1);
            instr = {op, 12'($urandom())};
            nextRA = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            floatOutReady = ($urandom_range(0, 2) == 0);
            isJeq = mpend && ($urandom_range(0, 3) == 0);
            jeqTaken = $urandom_range(0, 1);
            floatOut = 16'($urandom());
            r = $urandom_range(0, 15);
            if (mbusy[r] && mtag[r] < 2) begin
                floatOutSrc = mtag[r]; floatOutReg = 4'(r);
            end else begin
                floatOutSrc = 4'($urandom_range(0, 1)); floatOutReg = 4'($urandom_range(0, 15));
            end
            loadOutReady = ($urandom_range(0, 2) == 0);
            loadOut = 16'($urandom());
            r = $urandom_range(0, 15);
            if (mbusy[r] && mtag[r] >= 2) loadOutSrc = mtag[r];
            else loadOutSrc = 4'($urandom_range(2, 14));
            dbgAddr = 4'($urandom_range(0, 15));
            cycle();
        end
        quiet();

        // Asynchronous reset in the middle of a cycle.
        nextRA = 4'hF; push1(16'h1312); push1(16'h1456);
        nextRA = 4'h0; instrValid = 1; instr = 16'h1abc;
        #2 rst = 1;
        #1;
        chk("mid_we", writeEnabled, 0); chk("mid_line", line, 0);
        chk("mid_flush", flush, 0); chk("mid_illegal", illegal, 0);
        chk("mid_ready", instrReady, 1);
        for (int i = 0; i < 16; i++) begin
            dbgAddr = 4'(i);
            #1 chk("mid_dbg", dbgData, 0);
        end
        @(negedge clk);
        quiet(); dbgAddr = 0; rst = 0;
        model_reset();
        push1(16'h1312);
        nextRA = 4'h0; cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Dispatch stage directly upstream of the floating adder reservation stations.
- Buffers fetched 16-bit instructions in a FIFO and reads operands from a 16-entry register file with a per-register tag table.
- Builds the 51-bit station line and writes it into the station named by nextRA.
- Snoops the float and load result buses to retire register tags, forward operands, and resolve jeq.

Parameters:
DEPTH, 8, instruction FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
instrValid  in  1  fetch offers instr this cycle
instr  in  16  [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb
instrReady  out  1  FIFO not full
nextRA  in  4  free station index from adder; 4'hF = none free
writeEnabled  out  1  line valid, station write this edge
line  out  51  station entry
floatOutReady  in  1  adder result bus valid
floatOut  in  16  result value
floatOutSrc  in  4  producing station tag
floatOutReg  in  4  destination reg; 4'hF = none
isJeq  in  1  bus carries jeq resolution
jeqTaken  in  1  jeq resolved equal
loadOutReady  in  1  load bus valid
loadOut  in  16  load value
loadOutSrc  in  4  load tag (2..14)
flush  out  1  one-cycle pulse on taken jeq
illegal  out  1  one-cycle pulse: unsupported opcode popped
dbgAddr  in  4  debug register select
dbgData  out  16  regfile[dbgAddr], combinational

Behaviour:
- Reset (async): FIFO empty, all regs 0, all tags not-busy, jeqPending=0. Outputs: writeEnabled=0, line=0, flush=0, illegal=0, instrReady=1.
- FIFO push: instrValid && instrReady at posedge. Pop on dispatch or illegal. Push and pop in the same cycle are allowed. Pointers wrap mod DEPTH.
- Dispatch condition (combinational): FIFO non-empty && head opcode in {1,5,6} && nextRA != 4'hF && !jeqPending.
  - When true, writeEnabled=1. Pop and rename happen at the same edge.
  - Latency: an instruction pushed at edge N can dispatch at edge N+1.
- Line format:
  - [50:47] reg = rd
  - [46] busy = 1
  - [45:42] opcode
  - [41:26] value0, [25] ready0, [24:21] src0
  - [20:5] value1, [4] ready1, [3:0] src1
  - When writeEnabled=0, line=0.
- Operand read, for each of ra and rb:
  - Tag not busy: value = reg, ready = 1, src = 4'hF.
  - Tag busy and the float bus (or load bus) broadcasts a matching tag this cycle: value = bus value, ready = 1, src = 4'hF (same-cycle bypass).
  - Otherwise: value = 0, ready = 0, src = tag.
- Opcode 5: operand 1 = {12'b0, rb}, ready1 = 1, src1 = 4'hF.
- Rename: opcodes 1 and 5 set tag[rd] = {busy, nextRA}. Opcode 6 renames nothing; its reg field carries rd as the branch offset.
- Operands are read before rename, so rd == ra reads the old mapping.
- Writeback:
  - Float bus: floatOutReady && !isJeq && floatOutReg != 4'hF && tag[floatOutReg] busy with matching tag → write floatOut, clear busy.
  - Load bus: loadOutReady → every busy reg whose tag == loadOutSrc gets loadOut and is cleared.
  - Same-edge rename of the same reg wins over writeback; the value is still written and busy stays set with the new tag.
- Float and load buses together: both applied. Tags are disjoint (stations 0,1; loads 2..14).
- Jeq handling:
  - Dispatching opcode 6 sets jeqPending.
  - floatOutReady && isJeq clears jeqPending.
  - If jeqTaken is also set: flush=1 next cycle, FIFO emptied at that edge, push in that cycle dropped, tags and regs untouched.
- Unsupported opcode at head: popped without dispatch; illegal pulses next cycle.
- Reset mid-operation clears everything immediately. The adder is reset separately.

Test Plan:
- Reset, push 0x1312 (add r3=r1+r2), nextRA=0 → next cycle writeEnabled=1, line = reg 3, opcode 1, value0=0, ready0=1, src0=F, value1=0, ready1=1, src1=F; tag[3] = busy, tag 0.
- Push 0x1312 then 0x1434 with nextRA=0 then 1 → second line has ready0=0, src0=0. Then float bus (src 0, reg 3, value 0x0042) → dbgData[3]=0x0042, tag[3] clear.
- Dependent dispatch in the same cycle as float broadcast (src 0, value 0x1234) → line has value0=0x1234, ready0=1, src0=F.
- nextRA=F with 8 instructions queued → writeEnabled=0, instrReady=0; 9th push ignored. nextRA=1 → dispatch, instrReady=1 next cycle.
- Dispatch 0x6512 (jeq), push 3 more; later isJeq=1, jeqTaken=1 → no dispatch while pending, flush pulse, FIFO empty. Same with jeqTaken=0 → dispatch resumes, no flush.
- Push opcode 0xF instruction → illegal pulse, no writeEnabled. Assert rst mid-stream → all outputs 0 asynchronously, dbgData=0 for all registers.
